// File: rtl/fall_sequencer.sv
// Slot-based game sequencer for the 8x8 dodge game: schedules falling obstacles,
// tracks the player lane, detects collisions and keeps the BCD survival score.
module fall_sequencer #(
  parameter int unsigned N_OBJ     = 5,
  parameter int unsigned SPAWN_GAP = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        CLK,
  input  logic        clear_n,
  input  logic        step_tick,
  input  logic        start,
  input  logic        left,
  input  logic        right,
  output logic [63:0] obst_map,
  output logic [2:0]  player_lane,
  output logic [1:0]  game_state,
  output logic        game_over,
  output logic [7:0]  score_bcd
);

  localparam int unsigned CW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(SPAWN_GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t state, state_next;

  logic [N_OBJ-1:0] act, act_nx;
  logic [2:0]       lane  [N_OBJ];
  logic [2:0]       lane_nx [N_OBJ];
  logic [2:0]       depth [N_OBJ];
  logic [2:0]       depth_nx [N_OBJ];
  logic [2:0]       plane, plane_nx;
  logic [7:0]       score, score_nx;
  logic [7:0]       lfsr, lfsr_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             collide;
  logic             spawn;
  logic             placed;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Collision looks only at registered state; depth >= 6 means depth[2:1] == 2'b11.
  always_comb begin
    collide = 1'b0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      if (act[i] && (lane[i] == plane) && (depth[i][2:1] == 2'b11))
        collide = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (collide) state_next = OVER;
      OVER:    if (start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    obst_map = '0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      if (act[i])
        obst_map[{lane[i], depth[i]}] = 1'b1;
    end
    game_state  = state;
    game_over   = (state == OVER);
    player_lane = plane;
    score_bcd   = score;
  end

  always_comb begin
    act_nx   = act;
    lane_nx  = lane;
    depth_nx = depth;
    plane_nx = plane;
    score_nx = score;
    lfsr_nx  = lfsr;
    cnt_nx   = cnt;
    spawn    = 1'b0;
    placed   = 1'b0;
    // Leaving OVER clears the playfield on the same edge so IDLE never shows stale objects.
    if ((state == IDLE) || ((state == OVER) && start)) begin
      act_nx = '0;
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        lane_nx[i]  = '0;
        depth_nx[i] = '0;
      end
      plane_nx = 3'd3;
      score_nx = '0;
      lfsr_nx  = LFSR_SEED;
      cnt_nx   = ((state == IDLE) && start) ? GAP_LAST : '0;
    end else if (state == RUN) begin
      if (step_tick) begin
        for (int unsigned i = 0; i < N_OBJ; i++) begin
          if (act[i]) begin
            if (depth[i] == 3'd7) begin
              act_nx[i] = 1'b0;
              score_nx  = bcd_inc(score_nx);
            end else begin
              depth_nx[i] = depth[i] + 3'd1;
            end
          end
        end
        spawn  = (cnt == GAP_LAST);
        cnt_nx = spawn ? '0 : cnt + CW'(1);
        // A slot freed by this tick's exit is eligible for this tick's spawn.
        if (spawn) begin
          for (int unsigned i = 0; i < N_OBJ; i++) begin
            if (!placed && !act_nx[i]) begin
              act_nx[i]   = 1'b1;
              lane_nx[i]  = lfsr[2:0];
              depth_nx[i] = '0;
              placed      = 1'b1;
            end
          end
        end
        lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      if (left && !right && (plane != 3'd0))
        plane_nx = plane - 3'd1;
      else if (right && !left && (plane != 3'd7))
        plane_nx = plane + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      act <= '0;
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        lane[i]  <= '0;
        depth[i] <= '0;
      end
      plane <= 3'd3;
      score <= '0;
      lfsr  <= LFSR_SEED;
      cnt   <= '0;
    end else begin
      act   <= act_nx;
      lane  <= lane_nx;
      depth <= depth_nx;
      plane <= plane_nx;
      score <= score_nx;
      lfsr  <= lfsr_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_fall_sequencer.sv
// Scoreboard bench for fall_sequencer: two configurations driven in lockstep,
// each checked against an object-list reference model of the game rules.
module tb_fall_sequencer;

  logic CLK = 1'b0;
  logic clear_n = 1'b1;
  logic step_tick = 1'b0, start = 1'b0, left = 1'b0, right = 1'b0;

  logic [63:0] map0, map1;
  logic [2:0]  lane0, lane1;
  logic [1:0]  gs0, gs1;
  logic        go0, go1;
  logic [7:0]  sc0, sc1;

  always #5 CLK = ~CLK;

  fall_sequencer #(.N_OBJ(5), .SPAWN_GAP(2), .LFSR_SEED(8'hA5)) dut0 (
    .CLK(CLK), .clear_n(clear_n), .step_tick(step_tick), .start(start),
    .left(left), .right(right), .obst_map(map0), .player_lane(lane0),
    .game_state(gs0), .game_over(go0), .score_bcd(sc0)
  );

  fall_sequencer #(.N_OBJ(1), .SPAWN_GAP(1), .LFSR_SEED(8'hA5)) dut1 (
    .CLK(CLK), .clear_n(clear_n), .step_tick(step_tick), .start(start),
    .left(left), .right(right), .obst_map(map1), .player_lane(lane1),
    .game_state(gs1), .game_over(go1), .score_bcd(sc1)
  );

  typedef struct packed {
    logic [63:0] map;
    logic [2:0]  lane;
    logic [1:0]  gs;
    logic        go;
    logic [7:0]  sc;
  } out_t;

  out_t q0[$];
  out_t q1[$];
  int tests = 0;
  int fails = 0;

  // Reference model: an explicit list of objects per configuration, score kept as an integer.
  int       mst[2], mpl[2], msc[2], mcnt[2];
  bit [7:0] mlf[2];
  bit       mact[2][8];
  int       mln[2][8], mdp[2][8];

  function automatic int nobj(int d); return (d == 0) ? 5 : 1; endfunction
  function automatic int gap(int d);  return (d == 0) ? 2 : 1; endfunction

  task automatic model_reset(int d);
    mst[d] = 0; mpl[d] = 3; msc[d] = 0; mcnt[d] = 0; mlf[d] = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      mact[d][i] = 0; mln[d][i] = 0; mdp[d][i] = 0;
    end
  endtask

  task automatic model_step(int d, bit st, bit l, bit r, bit tk);
    bit coll;
    bit sp;
    coll = 0;
    case (mst[d])
      0: if (st) begin mst[d] = 1; mcnt[d] = gap(d) - 1; end
      1: begin
        for (int i = 0; i < nobj(d); i++)
          if (mact[d][i] && mln[d][i] == mpl[d] && mdp[d][i] >= 6) coll = 1;
        if (tk) begin
          for (int i = 0; i < nobj(d); i++) begin
            if (mact[d][i]) begin
              if (mdp[d][i] == 7) begin
                mact[d][i] = 0;
                if (msc[d] < 99) msc[d]++;
              end else mdp[d][i]++;
            end
          end
          sp = (mcnt[d] == gap(d) - 1);
          mcnt[d] = sp ? 0 : mcnt[d] + 1;
          if (sp) begin
            for (int i = 0; i < nobj(d); i++) begin
              if (!mact[d][i]) begin
                mact[d][i] = 1; mln[d][i] = int'(mlf[d] % 8); mdp[d][i] = 0;
                break;
              end
            end
          end
          mlf[d] = {mlf[d][6:0], mlf[d][7] ^ mlf[d][5] ^ mlf[d][4] ^ mlf[d][3]};
        end
        if (l && !r && mpl[d] > 0) mpl[d]--;
        if (r && !l && mpl[d] < 7) mpl[d]++;
        if (coll) mst[d] = 2;
      end
      default: if (st) model_reset(d);
    endcase
  endtask

  function automatic out_t model_out(int d);
    out_t o;
    o.map = '0;
    for (int i = 0; i < 8; i++)
      if (mact[d][i]) o.map[mln[d][i] * 8 + mdp[d][i]] = 1'b1;
    o.lane = 3'(mpl[d]);
    o.gs   = 2'(mst[d]);
    o.go   = (mst[d] == 2);
    o.sc   = {4'(msc[d] / 10), 4'(msc[d] % 10)};
    return o;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_out(string tag, out_t a, out_t e);
    check({tag, ".obst_map"},    a.map,  e.map);
    check({tag, ".player_lane"}, a.lane, e.lane);
    check({tag, ".game_state"},  a.gs,   e.gs);
    check({tag, ".game_over"},   a.go,   e.go);
    check({tag, ".score_bcd"},   a.sc,   e.sc);
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit after the edge.
  initial begin
    out_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp_out("cfg0", {map0, lane0, gs0, go0, sc0}, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp_out("cfg1", {map1, lane1, gs1, go1, sc1}, e);
      end
    end
  end

  task automatic step(bit st, bit l, bit r, bit tk);
    @(posedge CLK);
    #2;
    start = st; left = l; right = r; step_tick = tk;
    for (int d = 0; d < 2; d++) model_step(d, st, l, r, tk);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic tick_n(int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
  endtask

  // Called away from a clock edge with the scoreboard queues drained.
  task automatic do_reset();
    start = 0; left = 0; right = 0; step_tick = 0;
    clear_n = 1'b0;
    #1;
    check("rst.obst_map0", map0, 64'h0);
    check("rst.obst_map1", map1, 64'h0);
    check("rst.player_lane0", lane0, 3'd3);
    check("rst.game_state0", gs0, 2'd0);
    check("rst.game_over0", go0, 1'b0);
    check("rst.score_bcd0", sc0, 8'h00);
    for (int d = 0; d < 2; d++) model_reset(d);
    @(posedge CLK);
    #5;
    clear_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // First spawn lands in lane 5, depth 0.
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("first_spawn.obst_map", map0, 64'h1 << 40);
    check("first_spawn.player_lane", lane0, 3'd3);
    check("first_spawn.game_state", gs0, 2'd1);
    tick_n(8);
    check("exit_tick9.score_bcd", sc0, 8'h01);
    check("exit_tick9.game_over", go0, 1'b0);

    // Player steps into lane 5 and meets the first object at depth 6.
    @(posedge CLK); #5; do_reset();
    step(1, 0, 0, 0);
    tick_n(6);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    idle(2);
    check("collide.game_over", go0, 1'b1);
    check("collide.game_state", gs0, 2'd2);
    check("collide.score_bcd", sc0, 8'h00);
    for (int i = 0; i < 20; i++)
      step(0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);

    // Lane saturation and simultaneous pulses, no ticks so no objects.
    @(posedge CLK); #5; do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    idle(1);
    check("sat_left.player_lane", lane0, 3'd0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    idle(1);
    check("sat_right.player_lane", lane0, 3'd7);

    // Randomised play with occasional restarts and mid-game resets.
    @(posedge CLK); #5; do_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        @(posedge CLK); #5; do_reset();
      end else begin
        step($urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
      end
    end
    idle(1);
    @(posedge CLK);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
